oven_cook_sequencer: RTL and testbench



---
 rtl/oven_cook_sequencer.sv | 128 ++++++++++++
 tb/tb_oven_cook_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/oven_cook_sequencer.sv
// oven_cook_sequencer: preheat, thermostat hold, timed cook and completion buzzer.
// Define OVEN_DOOR_PAUSE_EN to add the door_open input that pauses PREHEAT/COOK.
module oven_cook_sequencer #(
  parameter int MIN_TEMP        = 65,
  parameter int MAX_TEMP        = 500,
  parameter int HYST            = 5,
  parameter int PREHEAT_TIMEOUT = 900,
  parameter int BUZZ_SECS       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        start,
  input  logic        cancel,
  input  logic [9:0]  target_temp,
  input  logic [12:0] target_time,
  input  logic [9:0]  current_temp,
`ifdef OVEN_DOOR_PAUSE_EN
  input  logic        door_open,
`endif
  output logic        heater_on,
  output logic [12:0] remaining_time,
  output logic [2:0]  state,
  output logic        done,
  output logic        buzzer,
  output logic        fault
);
  localparam int PW = $clog2(PREHEAT_TIMEOUT + 1);
  localparam int BW = $clog2(BUZZ_SECS + 1);
  localparam logic [9:0]    MIN_T = 10'(MIN_TEMP);
  localparam logic [9:0]    MAX_T = 10'(MAX_TEMP);
  localparam logic [9:0]    HY    = 10'(HYST);
  localparam logic [PW-1:0] PT_M1 = PW'(PREHEAT_TIMEOUT - 1);
  localparam logic [BW-1:0] BZ    = BW'(BUZZ_SECS);
  typedef enum logic [2:0] {IDLE = 3'd0, PREHEAT = 3'd1, COOK = 3'd2, DONE = 3'd3, FAULT = 3'd4} state_t;
  state_t st;
  logic [9:0] setpoint;
  logic [PW-1:0] preheat_cnt;
  logic [BW-1:0] buzz_cnt;
  logic door, valid, timeout, at_temp, too_cold;
`ifdef OVEN_DOOR_PAUSE_EN
  assign door = door_open;
`else
  assign door = 1'b0;
`endif
  assign state    = st;
  assign valid    = start && !door && target_time != 13'd0 && target_temp >= MIN_T && target_temp <= MAX_T;
  assign timeout  = tick_1hz && preheat_cnt == PT_M1;
  assign at_temp  = current_temp >= setpoint;
  assign too_cold = current_temp < setpoint - HY;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || cancel) begin
      st <= IDLE;
      heater_on <= 1'b0;
      remaining_time <= '0;
      done <= 1'b0;
      buzzer <= 1'b0;
      fault <= 1'b0;
      preheat_cnt <= '0;
      buzz_cnt <= '0;
      if (rst) setpoint <= '0;
    end else begin
      case (st)
        IDLE: begin
          heater_on <= valid;
          if (valid) begin
            setpoint <= target_temp;
            remaining_time <= target_time;
            preheat_cnt <= '0;
            st <= PREHEAT;
          end
        end
        PREHEAT: begin
          if (door) heater_on <= 1'b0;
          else if (at_temp) begin
            heater_on <= 1'b0;
            st <= COOK;
          end else begin
            heater_on <= !timeout;
            preheat_cnt <= preheat_cnt + PW'(tick_1hz);
            fault <= timeout;
            if (timeout) st <= FAULT;
          end
        end
        COOK: begin
          if (door) heater_on <= 1'b0;
          else if (tick_1hz && remaining_time <= 13'd1) begin
            heater_on <= 1'b0;
            remaining_time <= '0;
            done <= 1'b1;
            buzzer <= 1'b1;
            buzz_cnt <= BZ;
            st <= DONE;
          end else begin
            heater_on <= at_temp ? 1'b0 : too_cold ? 1'b1 : heater_on;
            if (tick_1hz) remaining_time <= remaining_time - 13'd1;
          end
        end
        DONE: begin
          heater_on <= 1'b0;
          if (start) begin
            done <= 1'b0;
            buzzer <= 1'b0;
            buzz_cnt <= '0;
            st <= IDLE;
          end else if (tick_1hz && buzz_cnt != '0) begin
            buzz_cnt <= buzz_cnt - BW'(1);
            if (buzz_cnt == BW'(1)) buzzer <= 1'b0;
          end
        end
        FAULT: begin
          heater_on <= 1'b0;
          fault <= 1'b1;
        end
        default: begin
          st <= IDLE;
          heater_on <= 1'b0;
          remaining_time <= '0;
          done <= 1'b0;
          buzzer <= 1'b0;
          fault <= 1'b0;
          preheat_cnt <= '0;
          buzz_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_oven_cook_sequencer.sv
// tb_oven_cook_sequencer: directed vectors with hand-computed expectations.
module tb_oven_cook_sequencer;
  logic clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [9:0] target_temp = '0, current_temp = '0;
  logic [12:0] target_time = '0;
  logic heater_on, done, buzzer, fault;
  logic [12:0] remaining_time;
  logic [2:0] state;
`ifdef OVEN_DOOR_PAUSE_EN
  logic door_open = 1'b0;
`endif
  int vecs = 0, errs = 0;
  oven_cook_sequencer dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .cancel(cancel),
    .target_temp(target_temp), .target_time(target_time), .current_temp(current_temp),
`ifdef OVEN_DOOR_PAUSE_EN
    .door_open(door_open),
`endif
    .heater_on(heater_on), .remaining_time(remaining_time), .state(state),
    .done(done), .buzzer(buzzer), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask
  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask
  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_heater", 32'(heater_on), 0);
    chk("rst_rem", 32'(remaining_time), 0);
    chk("rst_flags", {29'd0, done, buzzer, fault}, 0);
    target_temp = 10'd60; target_time = 13'd3;
    pulse_start();
    chk("low_temp_idle", 32'(state), 0);
    target_temp = 10'd501;
    pulse_start();
    chk("high_temp_idle", 32'(state), 0);
    target_temp = 10'd300; target_time = 13'd0;
    pulse_start();
    chk("zero_time_idle", 32'(state), 0);
    chk("zero_time_rem", 32'(remaining_time), 0);
    target_time = 13'd3; current_temp = 10'd200;
    pulse_start();
    chk("norm_preheat", 32'(state), 1);
    chk("norm_heat", 32'(heater_on), 1);
    chk("norm_rem3", 32'(remaining_time), 3);
    current_temp = 10'd250;
    tick();
    chk("norm_still_pre", 32'(state), 1);
    chk("norm_rem_hold", 32'(remaining_time), 3);
    current_temp = 10'd300;
    cyc();
    chk("norm_cook", 32'(state), 2);
    target_time = 13'd99; target_temp = 10'd400;
    tick();
    chk("norm_rem2", 32'(remaining_time), 2);
    tick();
    chk("norm_rem1", 32'(remaining_time), 1);
    tick();
    chk("norm_rem0", 32'(remaining_time), 0);
    chk("norm_done_state", 32'(state), 3);
    chk("norm_done", 32'(done), 1);
    chk("norm_buzz0", 32'(buzzer), 1);
    tick();
    chk("buzz_t1", 32'(buzzer), 1);
    tick();
    chk("buzz_t2", 32'(buzzer), 1);
    tick();
    chk("buzz_t3", 32'(buzzer), 0);
    chk("done_hold", 32'(done), 1);
    pulse_start();
    chk("done_start_idle", 32'(state), 0);
    chk("done_cleared", 32'(done), 0);
    target_temp = 10'd300; target_time = 13'd40; current_temp = 10'd300;
    pulse_start();
    cyc();
    chk("th_cook", 32'(state), 2);
    chk("th_300", 32'(heater_on), 0);
    current_temp = 10'd296; cyc();
    chk("th_296", 32'(heater_on), 0);
    current_temp = 10'd294; cyc();
    chk("th_294", 32'(heater_on), 1);
    current_temp = 10'd298; cyc();
    chk("th_298", 32'(heater_on), 1);
    chk("th_rem40", 32'(remaining_time), 40);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_heater", 32'(heater_on), 0);
    chk("arst_rem", 32'(remaining_time), 0);
    cyc();
    rst = 1'b0;
    target_time = 13'd1;
    pulse_start();
    cyc();
    chk("cx_rem1", 32'(remaining_time), 1);
    cancel = 1'b1; tick_1hz = 1'b1;
    cyc();
    cancel = 1'b0; tick_1hz = 1'b0;
    chk("cx_idle", 32'(state), 0);
    chk("cx_done", 32'(done), 0);
    target_time = 13'd5; current_temp = 10'd100;
    pulse_start();
    repeat (899) tick();
    chk("to_899_state", 32'(state), 1);
    chk("to_899_heat", 32'(heater_on), 1);
    tick();
    chk("to_fault_state", 32'(state), 4);
    chk("to_fault_heat", 32'(heater_on), 0);
    chk("to_fault_flag", 32'(fault), 1);
    pulse_start();
    chk("fault_start_ign", 32'(state), 4);
    cancel = 1'b1; cyc(); cancel = 1'b0;
    chk("fault_cancel", 32'(state), 0);
    chk("fault_cleared", 32'(fault), 0);
`ifdef OVEN_DOOR_PAUSE_EN
    target_time = 13'd10; current_temp = 10'd300;
    pulse_start();
    cyc();
    current_temp = 10'd290; cyc();
    chk("door_pre_heat", 32'(heater_on), 1);
    door_open = 1'b1;
    repeat (5) tick();
    chk("door_rem", 32'(remaining_time), 10);
    chk("door_heat", 32'(heater_on), 0);
    chk("door_state", 32'(state), 2);
    door_open = 1'b0; cyc();
    chk("door_release_heat", 32'(heater_on), 1);
    tick();
    chk("door_resume", 32'(remaining_time), 9);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
